router_chan_ctrl: RTL and testbench
===================================

Name: router_chan_ctrl

Overview:
Channel controller sitting between the router FSM and the three output FIFOs of the 1-to-3 packet router. It latches the destination address of each packet and decodes it into a one-hot FIFO write enable. It muxes the selected FIFO's full flag back to the FSM and drives per-channel valid-out flags. It also runs a per-channel read-timeout watchdog that issues a one-cycle soft reset when a destination leaves valid data unread too long.

Parameters:
TIMEOUT, 30, number of consecutive stalled clock edges before a channel's soft reset fires; legal range is TIMEOUT >= 2.
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
clock  in  1  system clock; all state updates on posedge.
resetn  in  1  synchronous, active-low reset.
detect_add  in  1  address-capture strobe from the router FSM.
data_in  in  2  destination address field of the header byte.
write_enb_reg  in  1  FSM request to write the current byte into the selected FIFO.
read_enb_0, read_enb_1, read_enb_2  in  1 each  destination read strobes.
empty_0, empty_1, empty_2  in  1 each  FIFO empty flags.
full_0, full_1, full_2  in  1 each  FIFO full flags.
write_enb  out  3  one-hot FIFO write enable; bit i selects FIFO i.
fifo_full  out  1  full flag of the currently addressed FIFO.
vld_out_0, vld_out_1, vld_out_2  out  1 each  FIFO holds data for the destination.
soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  one-cycle FIFO/FSM soft-reset pulse.

Behaviour:
- Reset: resetn sampled low at a posedge clears the following on that edge:
  - addr to 2'b00.
  - All three timeout counters to 0.
  - soft_reset_0/1/2 to 0.
- Reset has priority over every other event. Reset mid-count discards the count and no pulse is emitted.
- Address register: on posedge with detect_add=1, addr <= data_in. Otherwise addr holds.
- write_enb (combinational from registered addr):
  - write_enb_reg=0 -> 3'b000.
  - write_enb_reg=1, addr=00 -> 3'b001; addr=01 -> 3'b010; addr=10 -> 3'b100.
  - addr=11 (invalid) -> 3'b000.
- Same-cycle detect_add and write_enb_reg: write_enb decodes the old addr. The new address takes effect the next cycle.
- fifo_full (combinational): full_0, full_1 or full_2 selected by addr 00, 01 or 10; 0 when addr=11.
- vld_out_i = ~empty_i, combinational, no latency.
- Timeout watchdog (independent per channel i, evaluated each posedge, in priority order):
  1. vld_out_i=0 -> cnt_i <= 0, soft_reset_i <= 0.
  2. Else if read_enb_i=1 -> cnt_i <= 0, soft_reset_i <= 0.
  3. Else if cnt_i == TIMEOUT-1 -> soft_reset_i <= 1, cnt_i <= 0.
  4. Else cnt_i <= cnt_i+1, soft_reset_i <= 0.
- Net timing: soft_reset_i goes high in the cycle after the TIMEOUT-th consecutive edge with vld_out_i=1 and read_enb_i=0. It stays high for exactly one cycle.
- If the stall persists, a further pulse follows every TIMEOUT edges. The counter never wraps past TIMEOUT-1.
- A single read_enb_i edge anywhere in the window restarts the count from 0.
- soft_reset_i is purely a registered output. It does not clear addr or the other channels' counters.
- All three channels may pulse in the same cycle.

Test Plan:
- Reset: hold resetn=0 for 2 edges with empty_*=0 and read_enb_*=0 -> addr=00, soft_reset_*=0; the first pulse occurs only TIMEOUT (30) edges after release.
- Address decode: detect_add=1, data_in=01, then write_enb_reg=1 -> write_enb=3'b010. With full_1=1 -> fifo_full=1. With full_1=0, full_0=1 -> fifo_full=0.
- Invalid and overlapping address: latch data_in=11, assert write_enb_reg=1 -> write_enb=000 and fifo_full=0. Then assert detect_add with data_in=10 and write_enb_reg both high -> write_enb=000 that cycle and 3'b100 the next.
- Timeout fires: empty_2=0, read_enb_2=0 for 30 edges -> soft_reset_2=1 exactly in cycle 31, 0 in cycles 1-30 and 32; soft_reset_0/1 stay 0.
- Read restarts count: empty_0=0, read_enb_0=1 only at edge 29 -> no pulse at cycle 31; pulse appears at cycle 60 (30 edges after edge 29).
- Empty and reset abort: empty_1 rises at edge 15 -> vld_out_1=0 immediately and cnt_1 is cleared. Separately, resetn=0 at edge 20 of a stall -> no soft_reset_1 pulse at cycle 31.

Source files
------------

// File: rtl/router_chan_ctrl.sv
// router_chan_ctrl: header address latch, one-hot FIFO write decode, full-flag mux and per-channel read-timeout watchdog
//   clock, resetn                  : clock, synchronous active-low reset
//   detect_add, data_in            : header capture strobe and destination address
//   write_enb_reg                  : FSM write request, decoded into write_enb
//   read_enb_*, empty_*, full_*    : per-channel destination reads and FIFO flags
//   write_enb, fifo_full           : one-hot FIFO write enable, full flag of addressed FIFO
//   vld_out_*, soft_reset_*        : data-available flags, one-cycle watchdog soft resets
module router_chan_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);
  logic [1:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       srst_q, srst_d;
  logic [2:0]       vld, rd;

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};
  assign {vld_out_2, vld_out_1, vld_out_0} = vld;
  assign {soft_reset_2, soft_reset_1, soft_reset_0} = srst_q;

  assign addr_d = detect_add ? data_in : addr_q;

  // Decode uses the registered address, so a same-cycle capture applies next cycle
  assign write_enb = (write_enb_reg && addr_q != 2'b11) ? (3'b001 << addr_q) : 3'b000;
  assign fifo_full = addr_q == 2'b00 ? full_0 :
                     addr_q == 2'b01 ? full_1 :
                     addr_q == 2'b10 ? full_2 : 1'b0;

  // Counter restarts on no data or a read; at TIMEOUT-1 it fires and restarts, so it never wraps
  always_comb begin
    srst_d = '0;
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = '0;
      if (vld[c] && !rd[c]) begin
        srst_d[c] = cnt_q[c] == CNT_W'(TIMEOUT - 1);
        cnt_d[c]  = srst_d[c] ? '0 : cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q <= 2'b00;
      srst_q <= '0;
      for (int c = 0; c < 3; c++) cnt_q[c] <= '0;
    end else begin
      addr_q <= addr_d;
      srst_q <= srst_d;
      for (int c = 0; c < 3; c++) cnt_q[c] <= cnt_d[c];
    end
  end
endmodule

// File: tb/tb_router_chan_ctrl.sv
// tb_router_chan_ctrl: directed self-checking bench for router_chan_ctrl
module tb_router_chan_ctrl;
  logic       clock = 1'b0;
  logic       resetn, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  int         errors = 0;
  int         checks = 0;

  router_chan_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  wire [2:0] srst = {soft_reset_2, soft_reset_1, soft_reset_0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'b00;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b000;
    {full_2, full_1, full_0} = 3'b000;
    tick();
    tick();
    chk("reset_srst", srst, 3'b000);
    write_enb_reg = 1'b1;
    #1 chk("reset_addr_dec", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    chk("vld_all", {vld_out_2, vld_out_1, vld_out_0}, 3'b111);
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k >= 29) chk($sformatf("reset_first_pulse_e%0d", k), srst, k == 30 ? 3'b111 : 3'b000);
    end
    {empty_2, empty_1, empty_0} = 3'b111;
    tick();
    chk("vld_none", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);
    chk("idle_srst", srst, 3'b000);

    detect_add = 1'b1; data_in = 2'b01;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_1 = 1'b1;
    #1 chk("dec_01", write_enb, 3'b010);
    chk("full_sel1", {2'b00, fifo_full}, 3'b001);
    full_1 = 1'b0; full_0 = 1'b1;
    #1 chk("full_other", {2'b00, fifo_full}, 3'b000);
    write_enb_reg = 1'b0;
    #1 chk("dec_off", write_enb, 3'b000);

    detect_add = 1'b1; data_in = 2'b11;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; {full_2, full_1, full_0} = 3'b111;
    #1 chk("dec_11", write_enb, 3'b000);
    chk("full_11", {2'b00, fifo_full}, 3'b000);
    detect_add = 1'b1; data_in = 2'b10;
    #1 chk("overlap_old", write_enb, 3'b000);
    tick();
    detect_add = 1'b0;
    #1 chk("overlap_new", write_enb, 3'b100);
    full_2 = 1'b0;
    #1 chk("full_sel2", {2'b00, fifo_full}, 3'b000);
    write_enb_reg = 1'b0; {full_2, full_1, full_0} = 3'b000;

    empty_2 = 1'b0;
    #1 chk("vld2", {vld_out_2, vld_out_1, vld_out_0}, 3'b100);
    for (int k = 1; k <= 61; k++) begin
      tick();
      chk($sformatf("to2_e%0d", k), srst, (k == 30 || k == 60) ? 3'b100 : 3'b000);
    end
    empty_2 = 1'b1;
    tick();

    empty_0 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      read_enb_0 = (k == 29);
      tick();
      read_enb_0 = 1'b0;
      chk($sformatf("rd0_e%0d", k), srst, k == 59 ? 3'b001 : 3'b000);
    end
    empty_0 = 1'b1;
    tick();

    for (int k = 1; k <= 46; k++) begin
      empty_1 = (k == 15);
      if (k == 15) #1 chk("empty1_vld", {2'b00, vld_out_1}, 3'b000);
      tick();
      chk($sformatf("emp1_e%0d", k), srst, k == 45 ? 3'b010 : 3'b000);
    end
    empty_1 = 1'b1;
    tick();

    detect_add = 1'b1; data_in = 2'b10;
    tick();
    detect_add = 1'b0;
    empty_1 = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      resetn = (k != 20);
      tick();
      chk($sformatf("rst1_e%0d", k), srst, k == 50 ? 3'b010 : 3'b000);
    end
    resetn = 1'b1; write_enb_reg = 1'b1;
    #1 chk("rst_clears_addr", write_enb, 3'b001);
    write_enb_reg = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
